i2c_slave: RTL

- I2C target (slave) endpoint that answers the team's I2C master on the shared SCL/SDA bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches its own address, ACKs it, then either receives bytes (master write) or returns bytes (master read).
- Sits between the bus pins (open-drain, via SDA_oe) and a local byte-wide data interface.

---
 rtl/i2c_slave.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, address match,
// byte receive with ACK and byte transmit with master ACK/NACK handling.
`timescale 1ns/1ps
module i2c_slave #(
  parameter int                       ADDRESSLENGTH = 7,
  parameter logic [ADDRESSLENGTH-1:0] OWN_ADDRESS   = 7'h42,
  parameter bit                       LSB_FIRST     = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_oe,
  input  logic [7:0] TxData,
  output logic       TxReq,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       RorW,
  output logic       Busy
);

  localparam logic [3:0] ADDR_BITS = 4'(ADDRESSLENGTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } state_t;

  state_t                   state, state_next;
  logic [3:0]               bit_cnt, cnt_next;
  logic [1:0]               scl_sync, sda_sync;
  logic                     scl_hist, sda_hist;
  logic [ADDRESSLENGTH-1:0] addr_sr, addr_next;
  logic [7:0]               shift, shift_next;
  logic                     oe_next, txreq_next, rxvalid_next, rorw_next, busy_next;
  logic [7:0]               rxdata_next;

  logic                     scl, sda;
  logic                     scl_rise, scl_fall, start_cond, stop_cond;
  logic [ADDRESSLENGTH-1:0] addr_shifted;
  logic [7:0]               rx_shifted, tx_shifted;
  logic                     tx_first_bit, tx_next_bit;

  assign scl        = scl_sync[1];
  assign sda        = sda_sync[1];
  assign scl_rise   = scl & ~scl_hist;
  assign scl_fall   = ~scl & scl_hist;
  assign start_cond = scl & scl_hist & sda_hist & ~sda;
  assign stop_cond  = scl & scl_hist & ~sda_hist & sda;

  // Bit-order helpers: the wire order is fixed by LSB_FIRST for address and data.
  assign addr_shifted = LSB_FIRST ? {sda, addr_sr[ADDRESSLENGTH-1:1]}
                                  : {addr_sr[ADDRESSLENGTH-2:0], sda};
  assign rx_shifted   = LSB_FIRST ? {sda, shift[7:1]} : {shift[6:0], sda};
  assign tx_shifted   = LSB_FIRST ? {1'b0, shift[7:1]} : {shift[6:0], 1'b0};
  assign tx_first_bit = LSB_FIRST ? TxData[0] : TxData[7];
  assign tx_next_bit  = LSB_FIRST ? shift[1] : shift[6];

  always_ff @(posedge CLK) begin
    if (RST) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
      state    <= IDLE;
      bit_cnt  <= '0;
      addr_sr  <= '0;
      shift    <= '0;
      SDA_oe   <= 1'b0;
      TxReq    <= 1'b0;
      RxData   <= 8'h00;
      RxValid  <= 1'b0;
      RorW     <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], SCL_in};
      sda_sync <= {sda_sync[0], SDA_in};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
      state    <= state_next;
      bit_cnt  <= cnt_next;
      addr_sr  <= addr_next;
      shift    <= shift_next;
      SDA_oe   <= oe_next;
      TxReq    <= txreq_next;
      RxData   <= rxdata_next;
      RxValid  <= rxvalid_next;
      RorW     <= rorw_next;
      Busy     <= busy_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = bit_cnt;
    addr_next    = addr_sr;
    shift_next   = shift;
    oe_next      = SDA_oe;
    txreq_next   = 1'b0;
    rxvalid_next = 1'b0;
    rxdata_next  = RxData;
    rorw_next    = RorW;
    busy_next    = Busy;

    if (start_cond) begin
      state_next = ADDR;
      oe_next    = 1'b0;
      busy_next  = 1'b0;
    end else if (stop_cond) begin
      state_next = IDLE;
      oe_next    = 1'b0;
      busy_next  = 1'b0;
    end else begin
      case (state)
        IDLE: oe_next = 1'b0;

        ADDR: begin
          if (scl_rise) begin
            if (bit_cnt == ADDR_BITS) begin
              if (addr_sr == OWN_ADDRESS) begin
                rorw_next  = sda;
                busy_next  = 1'b1;
                txreq_next = sda;
                state_next = ADDR_ACK;
              end else begin
                state_next = WAIT_STOP;
              end
            end else begin
              addr_next = addr_shifted;
              cnt_next  = bit_cnt + 4'd1;
            end
          end
        end

        // For a read the ACK slot hands over to TX_BYTE while SCL is high;
        // the fall that ends the ACK then drives the first data bit.
        ADDR_ACK, RX_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              oe_next  = 1'b1;
              cnt_next = 4'd1;
            end else if (!RorW) begin
              oe_next    = 1'b0;
              state_next = RX_BYTE;
            end
          end else if (scl_rise && bit_cnt == 4'd1 && RorW) begin
            state_next = TX_BYTE;
          end
        end

        RX_BYTE: begin
          if (scl_rise) begin
            shift_next = rx_shifted;
            if (bit_cnt == 4'd7) begin
              rxdata_next  = rx_shifted;
              rxvalid_next = 1'b1;
              state_next   = RX_ACK;
            end else begin
              cnt_next = bit_cnt + 4'd1;
            end
          end
        end

        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              shift_next = TxData;
              oe_next    = ~tx_first_bit;
              cnt_next   = 4'd1;
            end else if (bit_cnt == 4'd8) begin
              oe_next    = 1'b0;
              state_next = TX_ACK;
            end else begin
              shift_next = tx_shifted;
              oe_next    = ~tx_next_bit;
              cnt_next   = bit_cnt + 4'd1;
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (!sda) begin
              txreq_next = 1'b1;
              state_next = TX_BYTE;
            end else begin
              busy_next  = 1'b0;
              state_next = WAIT_STOP;
            end
          end
        end

        WAIT_STOP: oe_next = 1'b0;

        default: state_next = IDLE;
      endcase
    end

    if (state_next != state) cnt_next = '0;
  end

endmodule
